wavegen_dual: RTL

- Dual-channel, multi-mode waveform generator; next generation of the single-channel ROM sine generator.
- Fractional phase accumulator with a frequency-tuning word, so output frequency is finer than one ROM step.
- Channel B is phase-offset from channel A. Mode selects sine, square, triangle or sawtooth; amplitude scaling saturates.
- Feeds the DAC/output stage of the signal-generation path; consumes the team's existing synchronous-read rom block, one instance per channel.

---
 rtl/wavegen_dual_if.sv | 41 ++++
 rtl/wavegen_dual.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wavegen_dual_if.sv
// ---------------------------------------------------------------------------
// wavegen_dual_if
// Control/sample bundle between a wavegen_dual instance and whatever drives it.
//   en      : advance phase this cycle
//   sync    : clear phase accumulator to 0 (wins over en)
//   mode    : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   incr    : frequency tuning word
//   offset  : channel B phase offset in ROM address steps
//   amp     : gain, midscale = unity
//   dout_a  : channel A sample (unsigned offset-binary)
//   dout_b  : channel B sample
//   valid   : en delayed by the 2-cycle sample pipeline
//   wrap    : one-cycle pulse on accumulator carry-out
// master = controller side, slave = generator side.
// ---------------------------------------------------------------------------
interface wavegen_dual_if #(
  parameter int PHASE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
);
  logic                   en;
  logic                   sync;
  logic [1:0]             mode;
  logic [PHASE_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0]  offset;
  logic [DATA_WIDTH-1:0]  amp;
  logic [DATA_WIDTH-1:0]  dout_a;
  logic [DATA_WIDTH-1:0]  dout_b;
  logic                   valid;
  logic                   wrap;

  modport master (
    output en, sync, mode, incr, offset, amp,
    input  dout_a, dout_b, valid, wrap
  );

  modport slave (
    input  en, sync, mode, incr, offset, amp,
    output dout_a, dout_b, valid, wrap
  );
endinterface

// File: rtl/wavegen_dual.sv
// ---------------------------------------------------------------------------
// wavegen_dual
// Dual-channel multi-mode waveform generator. A fractional phase accumulator
// addresses one sine ROM per channel; channel B reads at a fixed address
// offset from channel A. Square/triangle/sawtooth are derived from the
// address directly. A saturating gain stage follows.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : wavegen_dual_if.slave (controls in, samples/valid/wrap out)
// Pipeline: phase reg -> stage 1 (ROM read / shape) -> stage 2 (gain, dout).
// ---------------------------------------------------------------------------

// Sine lookup with one-cycle synchronous read, one instance per channel.
// Entry i = round(MID + (MID-1)*sin(2*pi*i/2^AW)), so the table spans 1..2^DW-1.
module wavegen_dual_rom #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data
);
  function automatic logic [DW-1:0] sine_entry(input int idx);
    real mid;
    real ang;
    real v;
    mid = 2.0 ** (DW - 1);
    ang = 2.0 * 3.14159265358979323846 * idx / (2.0 ** AW);
    v   = mid + (mid - 1.0) * $sin(ang);
    return DW'($rtoi(v + 0.5));
  endfunction

  logic [DW-1:0] w_table [2**AW];

  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_tbl
    assign w_table[gi] = sine_entry(gi);
  end

  always_ff @(posedge clk) begin
    if (!rst) o_data <= '0;
    else      o_data <= w_table[i_addr];
  end
endmodule

module wavegen_dual #(
  parameter int PHASE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
) (
  input logic           clk,
  input logic           rst,
  wavegen_dual_if.slave bus
);
  localparam int PW = PHASE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  localparam int SH_UP = (DW >= AW) ? DW - AW : 0;
  localparam int SH_DN = (AW > DW) ? AW - DW : 0;
  localparam logic signed [2*DW+1:0] Y_MAX = $signed({{(DW+2){1'b0}}, {DW{1'b1}}});

  // Non-sine shapes straight from the address; returned at DW bits.
  function automatic logic [DW-1:0] shape_sample(input logic [1:0] m, input logic [AW-1:0] x);
    logic [AW-1:0] t;
    logic [AW-1:0] s;
    t = x[AW-1] ? ~(x << 1) : (x << 1);
    s = (m == 2'd2) ? t : x;
    if (m == 2'd1) return x[AW-1] ? '0 : '1;
    if (DW >= AW) return DW'(s) << SH_UP;
    return DW'(s >> SH_DN);
  endfunction

  // Gain around midscale: MID + ((raw-MID)*amp >>> (DW-1)), clamped.
  function automatic logic [DW-1:0] apply_gain(input logic [DW-1:0] raw, input logic [DW-1:0] gain);
    logic signed [DW:0]     c;
    logic signed [2*DW+1:0] p;
    logic signed [2*DW+1:0] y;
    c = $signed({1'b0, raw}) - $signed({1'b0, MID});
    p = c * $signed({1'b0, gain});
    y = $signed({{(DW+2){1'b0}}, MID}) + (p >>> (DW - 1));
    if (y < 0)     return '0;
    if (y > Y_MAX) return '1;
    return y[DW-1:0];
  endfunction

  // ---------------- phase accumulator ----------------
  logic [PW-1:0] r_phase;
  logic          r_wrap;
  logic [PW:0]   w_sum;

  assign w_sum = {1'b0, r_phase} + {1'b0, bus.incr};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.sync) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.en) begin
      r_phase <= w_sum[PW-1:0];
      r_wrap  <= w_sum[PW];
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // ---------------- stage 0: addresses ----------------
  logic [AW-1:0] w_xa;
  logic [AW-1:0] w_xb;
  logic [AW-1:0] w_x [2];

  assign w_xa   = r_phase[PW-1 -: AW];
  assign w_xb   = w_xa + bus.offset;
  assign w_x[0] = w_xa;
  assign w_x[1] = w_xb;

  // ---------------- stage 1: shared controls ----------------
  logic [1:0]    r_mode1;
  logic [DW-1:0] r_amp1;
  logic          r_live1;   // stage 1 holds a real sample (not reset filler)
  logic          r_valid1;
  logic          r_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode1  <= 2'd0;
      r_amp1   <= '0;
      r_live1  <= 1'b0;
      r_valid1 <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_mode1  <= bus.mode;
      r_amp1   <= bus.amp;
      r_live1  <= 1'b1;
      r_valid1 <= bus.en;
      r_valid  <= r_valid1;
    end
  end

  // ---------------- per-channel stage 1 / stage 2 ----------------
  logic [DW-1:0] w_dout [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [DW-1:0] w_rom_q;
    logic [DW-1:0] r_shape;
    logic [DW-1:0] w_raw;
    logic [DW-1:0] r_dout;

    wavegen_dual_rom #(.AW(AW), .DW(DW)) u_rom (
      .clk    (clk),
      .rst    (rst),
      .i_addr (w_x[gi]),
      .o_data (w_rom_q)
    );

    always_ff @(posedge clk) begin
      if (!rst) r_shape <= '0;
      else      r_shape <= shape_sample(bus.mode, w_x[gi]);
    end

    assign w_raw = (r_mode1 == 2'd0) ? w_rom_q : r_shape;

    // The first edge after reset would otherwise push reset filler
    // through the gain stage (amp=0 -> MID); hold dout at 0 instead.
    always_ff @(posedge clk) begin
      if (!rst)         r_dout <= '0;
      else if (r_live1) r_dout <= apply_gain(w_raw, r_amp1);
    end

    assign w_dout[gi] = r_dout;
  end

  assign bus.dout_a = w_dout[0];
  assign bus.dout_b = w_dout[1];
  assign bus.valid  = r_valid;
  assign bus.wrap   = r_wrap;
endmodule
